// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding select,
// load-use hazard detection and a RUN/BUBBLE/HOLD capture controller.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   i_id_valid                   ID holds a valid instruction
//   i_id_raddr1/2, i_id_rdata1/2 source register numbers and register-file data
//   i_match_1/2, i_match_data1/2 forwarding hits and forwarded operand values
//   i_id_waddr, i_id_reg_wr      destination register and write enable
//   i_id_mem_rd                  instruction is a load
//   i_id_alu_op, i_id_imm        ALU operation and immediate
//   i_id_use_imm                 operand B takes the immediate
//   i_ex_ready                   EX accepts the ID/EX contents this cycle
//   i_flush                      redirect; kill the ID instruction
//   o_ex_*                       registered EX-stage instruction fields
//   o_id_stall                   hold PC and IF/ID this cycle
//   o_load_use                   combinational load-use hazard
module id_ex_stage #(
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_id_valid,
  input  logic [4:0]         i_id_raddr1,
  input  logic [4:0]         i_id_raddr2,
  input  logic [31:0]        i_id_rdata1,
  input  logic [31:0]        i_id_rdata2,
  input  logic               i_match_1,
  input  logic               i_match_2,
  input  logic [31:0]        i_match_data1,
  input  logic [31:0]        i_match_data2,
  input  logic [4:0]         i_id_waddr,
  input  logic               i_id_reg_wr,
  input  logic               i_id_mem_rd,
  input  logic [ALUOP_W-1:0] i_id_alu_op,
  input  logic [31:0]        i_id_imm,
  input  logic               i_id_use_imm,
  input  logic               i_ex_ready,
  input  logic               i_flush,
  output logic               o_ex_valid,
  output logic [31:0]        o_ex_op_a,
  output logic [31:0]        o_ex_op_b,
  output logic [31:0]        o_ex_store_data,
  output logic [4:0]         o_ex_waddr,
  output logic               o_ex_reg_wr,
  output logic               o_ex_mem_rd,
  output logic [ALUOP_W-1:0] o_ex_alu_op,
  output logic               o_id_stall,
  output logic               o_load_use
);
  typedef enum logic [1:0] {RUN, BUBBLE, HOLD} state_t;
  state_t               r_state;
  logic                 r_ex_valid;
  logic [31:0]          r_ex_op_a;
  logic [31:0]          r_ex_op_b;
  logic [31:0]          r_ex_store_data;
  logic [4:0]           r_ex_waddr;
  logic                 r_ex_reg_wr;
  logic                 r_ex_mem_rd;
  logic [ALUOP_W-1:0]   r_ex_alu_op;
  logic [31:0]          w_src1;
  logic [31:0]          w_src2;
  logic                 w_lu_bubble;
  logic                 w_bubble;
  logic                 w_keep;

  // Register 0 always reads as zero, even when the forwarding unit reports a hit.
  assign w_src1 = (i_id_raddr1 == 5'd0) ? 32'd0 : i_match_1 ? i_match_data1 : i_id_rdata1;
  assign w_src2 = (i_id_raddr2 == 5'd0) ? 32'd0 : i_match_2 ? i_match_data2 : i_id_rdata2;

  assign o_load_use = r_ex_valid & r_ex_mem_rd & r_ex_reg_wr & (r_ex_waddr != 5'd0) & i_id_valid &
                      ((r_ex_waddr == i_id_raddr1) | (r_ex_waddr == i_id_raddr2));
  assign o_id_stall = o_load_use | ~i_ex_ready;

  // A bubble is inserted at most once per load: the cycle after a bubble the
  // load has moved to MEM and the ID instruction is captured with forwarding.
  assign w_lu_bubble = o_load_use & (r_state != BUBBLE);
  assign w_bubble    = i_flush | w_lu_bubble;
  assign w_keep      = i_id_valid & ~w_bubble;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= RUN;
      r_ex_valid      <= 1'b0;
      r_ex_op_a       <= 32'd0;
      r_ex_op_b       <= 32'd0;
      r_ex_store_data <= 32'd0;
      r_ex_waddr      <= 5'd0;
      r_ex_reg_wr     <= 1'b0;
      r_ex_mem_rd     <= 1'b0;
      r_ex_alu_op     <= '0;
    end else if (!i_ex_ready) begin
      r_state <= HOLD;
    end else begin
      r_state         <= (w_lu_bubble & ~i_flush) ? BUBBLE : RUN;
      r_ex_valid      <= w_keep;
      r_ex_reg_wr     <= w_keep & i_id_reg_wr;
      r_ex_mem_rd     <= w_keep & i_id_mem_rd;
      r_ex_op_a       <= w_src1;
      r_ex_op_b       <= i_id_use_imm ? i_id_imm : w_src2;
      r_ex_store_data <= w_src2;
      r_ex_waddr      <= i_id_waddr;
      r_ex_alu_op     <= i_id_alu_op;
    end
  end

  assign o_ex_valid      = r_ex_valid;
  assign o_ex_op_a       = r_ex_op_a;
  assign o_ex_op_b       = r_ex_op_b;
  assign o_ex_store_data = r_ex_store_data;
  assign o_ex_waddr      = r_ex_waddr;
  assign o_ex_reg_wr     = r_ex_reg_wr;
  assign o_ex_mem_rd     = r_ex_mem_rd;
  assign o_ex_alu_op     = r_ex_alu_op;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scoreboard bench for id_ex_stage.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n, id_valid, match_1, match_2, id_reg_wr, id_mem_rd, id_use_imm, ex_ready, flush;
  logic [4:0]  id_raddr1, id_raddr2, id_waddr;
  logic [31:0] id_rdata1, id_rdata2, match_data1, match_data2, id_imm;
  logic [3:0]  id_alu_op;
  logic        ex_valid, ex_reg_wr, ex_mem_rd, id_stall, load_use;
  logic [31:0] ex_op_a, ex_op_b, ex_store_data;
  logic [4:0]  ex_waddr;
  logic [3:0]  ex_alu_op;

  typedef struct packed {
    logic        v;
    logic        rw;
    logic        mr;
    logic        dc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic [4:0]  wa;
    logic [3:0]  op;
  } ex_t;

  ex_t q[$];
  ex_t m;
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.ALUOP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_id_valid(id_valid),
    .i_id_raddr1(id_raddr1), .i_id_raddr2(id_raddr2),
    .i_id_rdata1(id_rdata1), .i_id_rdata2(id_rdata2),
    .i_match_1(match_1), .i_match_2(match_2),
    .i_match_data1(match_data1), .i_match_data2(match_data2),
    .i_id_waddr(id_waddr), .i_id_reg_wr(id_reg_wr), .i_id_mem_rd(id_mem_rd),
    .i_id_alu_op(id_alu_op), .i_id_imm(id_imm), .i_id_use_imm(id_use_imm),
    .i_ex_ready(ex_ready), .i_flush(flush),
    .o_ex_valid(ex_valid), .o_ex_op_a(ex_op_a), .o_ex_op_b(ex_op_b),
    .o_ex_store_data(ex_store_data), .o_ex_waddr(ex_waddr),
    .o_ex_reg_wr(ex_reg_wr), .o_ex_mem_rd(ex_mem_rd), .o_ex_alu_op(ex_alu_op),
    .o_id_stall(id_stall), .o_load_use(load_use)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic id_in(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic m1, input logic [31:0] md1,
                       input logic m2, input logic [31:0] md2,
                       input logic [4:0] wa, input logic rw, input logic mr,
                       input logic [3:0] op, input logic [31:0] imm, input logic ui);
    id_valid = v; id_raddr1 = r1; id_raddr2 = r2; id_rdata1 = d1; id_rdata2 = d2;
    match_1 = m1; match_data1 = md1; match_2 = m2; match_data2 = md2;
    id_waddr = wa; id_reg_wr = rw; id_mem_rd = mr; id_alu_op = op; id_imm = imm; id_use_imm = ui;
  endtask

  // One clock: check combinational hazard outputs against the reference
  // model, push the expected EX contents, clock, then pop and compare.
  task automatic step();
    ex_t nx;
    ex_t e;
    logic lu;
    logic [31:0] s1, s2;
    lu = m.v & m.mr & m.rw & (m.wa != 5'd0) & id_valid & ((m.wa == id_raddr1) | (m.wa == id_raddr2));
    s1 = (id_raddr1 == 5'd0) ? 32'd0 : (match_1 ? match_data1 : id_rdata1);
    s2 = (id_raddr2 == 5'd0) ? 32'd0 : (match_2 ? match_data2 : id_rdata2);
    #1;
    if (rst_n) begin
      chk("load_use", {31'd0, load_use}, {31'd0, lu});
      chk("id_stall", {31'd0, id_stall}, {31'd0, lu | ~ex_ready});
    end
    if (!rst_n) nx = '{dc: 1'b1, default: '0};
    else if (!ex_ready) nx = m;
    else if (flush | lu) nx = '{default: '0};
    else nx = '{v: id_valid, rw: id_valid & id_reg_wr, mr: id_valid & id_mem_rd, dc: 1'b1,
                a: s1, b: id_use_imm ? id_imm : s2, s: s2, wa: id_waddr, op: id_alu_op};
    q.push_back(nx);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
    chk("ex_reg_wr", {31'd0, ex_reg_wr}, {31'd0, e.rw});
    chk("ex_mem_rd", {31'd0, ex_mem_rd}, {31'd0, e.mr});
    if (e.dc) begin
      chk("ex_op_a", ex_op_a, e.a);
      chk("ex_op_b", ex_op_b, e.b);
      chk("ex_store_data", ex_store_data, e.s);
      chk("ex_waddr", {27'd0, ex_waddr}, {27'd0, e.wa});
      chk("ex_alu_op", {28'd0, ex_alu_op}, {28'd0, e.op});
    end
    m = nx;
    @(negedge clk);
  endtask

  initial begin
    m = '0;
    rst_n = 1'b0; ex_ready = 1'b1; flush = 1'b0;
    id_in(1, 1, 2, 32'h11, 32'h22, 1, 32'h33, 1, 32'h44, 5'd7, 1, 1, 4'h5, 32'h66, 0);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    id_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("reset_load_use", {31'd0, load_use}, 32'd0);
    chk("reset_id_stall", {31'd0, id_stall}, 32'd0);
    step();
    id_in(1, 5, 6, 32'hDEAD, 32'h22, 1, 32'h1234, 0, 0, 5'd3, 1, 0, 4'h1, 0, 0);
    step();
    chk("fwd_op_a", ex_op_a, 32'h1234);
    chk("fwd_valid", {31'd0, ex_valid}, 32'd1);
    id_in(1, 7, 9, 32'h10, 32'h20, 0, 0, 1, 32'h99, 5'd4, 1, 0, 4'h2, 32'h55, 1);
    step();
    chk("imm_op_b", ex_op_b, 32'h55);
    chk("fwd_store", ex_store_data, 32'h99);
    id_in(1, 1, 2, 32'h100, 0, 0, 0, 0, 0, 5'd8, 1, 1, 4'h3, 32'h4, 1);
    step();
    id_in(1, 8, 0, 32'hAAAA, 0, 0, 0, 0, 0, 5'd9, 1, 0, 4'h1, 0, 0);
    #1 chk("lu_r8", {31'd0, load_use}, 32'd1);
    chk("lu_r8_stall", {31'd0, id_stall}, 32'd1);
    step();
    chk("lu_r8_bubble", {31'd0, ex_valid}, 32'd0);
    id_in(1, 8, 0, 32'hAAAA, 0, 1, 32'hBEEF, 0, 0, 5'd9, 1, 0, 4'h1, 0, 0);
    #1 chk("lu_r8_released", {31'd0, id_stall}, 32'd0);
    step();
    chk("lu_r8_capture", ex_op_a, 32'hBEEF);
    id_in(1, 3, 4, 0, 0, 0, 0, 0, 0, 5'd0, 1, 1, 4'h3, 0, 1);
    step();
    id_in(1, 0, 0, 32'hDEAD, 32'h77, 1, 32'hFFFFFFFF, 1, 32'h88, 5'd2, 1, 0, 4'h1, 0, 0);
    #1 chk("r0_no_lu", {31'd0, load_use}, 32'd0);
    step();
    chk("r0_op_a", ex_op_a, 32'd0);
    id_in(1, 1, 2, 32'h5, 0, 0, 0, 0, 0, 5'd10, 1, 1, 4'h3, 0, 1);
    step();
    id_in(1, 10, 0, 0, 0, 0, 0, 0, 0, 5'd11, 1, 1, 4'h3, 32'h8, 1);
    step();
    id_in(1, 10, 0, 0, 0, 1, 32'h1000, 0, 0, 5'd11, 1, 1, 4'h3, 32'h8, 1);
    step();
    id_in(1, 2, 11, 0, 0, 0, 0, 0, 0, 5'd12, 1, 0, 4'h1, 0, 0);
    step();
    id_in(1, 2, 11, 32'h3, 0, 0, 0, 1, 32'h2000, 5'd12, 1, 0, 4'h1, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      ex_ready = 1'b0;
      id_in(1, 5'(i + 1), 5'(i + 2), 32'(i * 17), 32'(i * 5), 0, 0, 0, 0, 5'(i + 20), 1, i[0], 4'(i), 0, 0);
      #1 chk("hold_stall", {31'd0, id_stall}, 32'd1);
      step();
      chk("hold_op_a", ex_op_a, 32'h3);
    end
    ex_ready = 1'b1;
    id_in(1, 13, 14, 32'h1313, 32'h1414, 0, 0, 0, 0, 5'd15, 1, 0, 4'h6, 0, 0);
    step();
    chk("hold_release", ex_op_a, 32'h1313);
    id_in(1, 1, 2, 0, 0, 0, 0, 0, 0, 5'd16, 1, 1, 4'h3, 0, 1);
    step();
    id_in(1, 16, 0, 32'h16, 0, 0, 0, 0, 0, 5'd17, 1, 0, 4'h1, 0, 0);
    flush = 1'b1;
    step();
    chk("flush_lu_valid", {31'd0, ex_valid}, 32'd0);
    flush = 1'b0;
    id_in(1, 16, 0, 32'h1616, 0, 0, 0, 0, 0, 5'd17, 1, 0, 4'h1, 0, 0);
    step();
    chk("flush_no_second_bubble", {31'd0, ex_valid}, 32'd1);
    id_in(1, 1, 2, 0, 0, 0, 0, 0, 0, 5'd18, 1, 1, 4'h3, 0, 1);
    step();
    id_in(1, 18, 0, 0, 0, 0, 0, 0, 0, 5'd19, 1, 0, 4'h1, 0, 0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    id_in(1, 4, 5, 32'h4444, 32'h5555, 0, 0, 0, 0, 5'd6, 1, 0, 4'h7, 0, 0);
    step();
    chk("post_reset_capture", ex_op_a, 32'h4444);
    id_in(0, 4, 5, 32'h1, 32'h2, 0, 0, 0, 0, 5'd6, 1, 1, 4'h2, 0, 0);
    step();
    ex_ready = 1'b0; flush = 1'b1;
    id_in(1, 7, 8, 32'h7, 32'h8, 0, 0, 0, 0, 5'd9, 1, 0, 4'h1, 0, 0);
    step();
    ex_ready = 1'b1; flush = 1'b0;
    id_in(1, 9, 10, 32'h9, 32'hA, 0, 0, 0, 0, 5'd11, 1, 0, 4'h8, 0, 0);
    step();
    chk("flush_not_remembered", {31'd0, ex_valid}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
